// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_shift_unit
// Purpose  : Iterative SHR/SHRA/SHL/ROR/ROL engine, STEP bits per cycle,
//            with a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int AMT_W = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [AMT_W:0] c_STEP  = (AMT_W+1)'(STEP);
    localparam logic [AMT_W:0] c_WIDTH = (AMT_W+1)'(WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_shifted;
    logic [2:0]       r_mode;
    logic [AMT_W-1:0] r_remaining;
    logic [AMT_W-1:0] w_new_amt;
    logic [AMT_W-1:0] w_step_amt;
    logic [AMT_W:0]   w_comp_amt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;
    logic             w_accept;
    logic             w_mode_illegal;
    logic             w_immediate;
    logic             w_last;
    logic             w_unused_amount;

    // Only the low AMT_W bits of the bus count matter: the count is modulo WIDTH.
    assign w_new_amt       = amount[AMT_W-1:0];
    assign w_unused_amount = ^amount[WIDTH-1:AMT_W];

    assign w_accept       = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_mode_illegal = (mode > 3'd4);
    assign w_immediate    = w_mode_illegal || (w_new_amt == '0);

    // When not the last step, STEP < remaining < WIDTH, so STEP fits in AMT_W bits.
    assign w_last     = ({1'b0, r_remaining} <= c_STEP);
    assign w_step_amt = w_last ? r_remaining : c_STEP[AMT_W-1:0];
    assign w_comp_amt = c_WIDTH - {1'b0, w_step_amt};

    always_comb begin
        w_shifted = r_work;
        case (r_mode)
            3'd0:    w_shifted = r_work >> w_step_amt;
            3'd1:    w_shifted = WIDTH'($signed(r_work) >>> w_step_amt);
            3'd2:    w_shifted = r_work << w_step_amt;
            3'd3:    w_shifted = (r_work >> w_step_amt) | (r_work << w_comp_amt);
            3'd4:    w_shifted = (r_work << w_step_amt) | (r_work >> w_comp_amt);
            default: w_shifted = r_work;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_IDLE;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (w_accept) begin
                    w_next_state = w_immediate ? c_DONE : c_SHIFT;
                end
            end
            c_SHIFT: w_next_state = w_last ? c_DONE : c_SHIFT;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_work      <= '0;
            r_mode      <= '0;
            r_remaining <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_work      <= data_in;
            r_mode      <= mode;
            r_remaining <= w_new_amt;
            if (w_immediate) begin
                r_result  <= data_in;
                r_zero    <= (data_in == '0);
                r_illegal <= w_mode_illegal;
            end else begin
                r_illegal <= 1'b0;
            end
        end else if (r_state == c_SHIFT) begin
            r_work      <= w_shifted;
            r_remaining <= r_remaining - w_step_amt;
            r_illegal   <= 1'b0;
            if (w_last) begin
                r_result <= w_shifted;
                r_zero   <= (w_shifted == '0);
            end
        end else begin
            r_illegal <= 1'b0;
        end
    end

    always_comb begin
        busy    = (r_state == c_SHIFT);
        done    = (r_state == c_DONE);
        result  = r_result;
        zero    = r_zero;
        illegal = r_illegal;
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_shift_unit
// Purpose  : Directed plus random checks of seq_shift_unit at STEP=1 and STEP=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_shift_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] amount = 32'd0;

    logic        busy_a, done_a, zero_a, illegal_a;
    logic        busy_b, done_b, zero_b, illegal_b;
    logic [31:0] result_a, result_b;

    int total = 0;
    int bad   = 0;
    logic sel = 1'b0;

    logic        busy_s, done_s, zero_s, illegal_s;
    logic [31:0] result_s;
    assign busy_s    = sel ? busy_b    : busy_a;
    assign done_s    = sel ? done_b    : done_a;
    assign zero_s    = sel ? zero_b    : zero_a;
    assign illegal_s = sel ? illegal_b : illegal_a;
    assign result_s  = sel ? result_b  : result_a;

    seq_shift_unit #(.WIDTH(32), .STEP(1)) u_dut_a (
        .clock(clock), .clear(clear), .start(start_a), .mode(mode),
        .data_in(data_in), .amount(amount), .busy(busy_a), .done(done_a),
        .result(result_a), .zero(zero_a), .illegal(illegal_a)
    );

    seq_shift_unit #(.WIDTH(32), .STEP(4)) u_dut_b (
        .clock(clock), .clear(clear), .start(start_b), .mode(mode),
        .data_in(data_in), .amount(amount), .busy(busy_b), .done(done_b),
        .result(result_b), .zero(zero_b), .illegal(illegal_b)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bitwise reference: each output bit is picked from its source position.
    function automatic logic [31:0] ref_shift(input logic [2:0] m, input logic [31:0] x,
                                              input logic [31:0] amt);
        int n;
        logic [31:0] r;
        n = amt % 32;
        r = x;
        if (m <= 3'd4) begin
            for (int i = 0; i < 32; i++) begin
                case (m)
                    3'd0: r[i] = (i + n < 32) ? x[i + n] : 1'b0;
                    3'd1: r[i] = (i + n < 32) ? x[i + n] : x[31];
                    3'd2: r[i] = (i >= n) ? x[i - n] : 1'b0;
                    3'd3: r[i] = x[(i + n) % 32];
                    default: r[i] = x[(i - n + 32) % 32];
                endcase
            end
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic s, input logic [2:0] m, input logic [31:0] amt);
        int n;
        int step;
        n = amt % 32;
        step = s ? 4 : 1;
        if (m > 3'd4 || n == 0) return 0;
        return (n + step - 1) / step;
    endfunction

    task automatic set_start(input logic s, input logic v);
        if (s) start_b = v;
        else   start_a = v;
    endtask

    task automatic issue(input logic s, input logic [2:0] m, input logic [31:0] d,
                         input logic [31:0] a);
        sel = s;
        mode = m;
        data_in = d;
        amount = a;
        set_start(s, 1'b1);
        tick();
        set_start(s, 1'b0);
    endtask

    // Waits from just after an accepting edge until done, checking timing and outputs.
    task automatic wait_done(input string tag, input int exp_edges, input logic [31:0] exp_res,
                             input logic exp_ill);
        int cnt;
        int busy_cnt;
        cnt = 0;
        busy_cnt = 0;
        while (done_s !== 1'b1 && cnt < 300) begin
            if (busy_s === 1'b1) busy_cnt++;
            tick();
            cnt++;
        end
        check({tag, " done"}, {31'd0, done_s}, 32'd1);
        check({tag, " latency"}, cnt, exp_edges);
        check({tag, " busy cycles"}, busy_cnt, exp_edges);
        check({tag, " busy in done"}, {31'd0, busy_s}, 32'd0);
        check({tag, " result"}, result_s, exp_res);
        check({tag, " zero"}, {31'd0, zero_s}, {31'd0, exp_res == 32'd0});
        check({tag, " illegal"}, {31'd0, illegal_s}, {31'd0, exp_ill});
    endtask

    task automatic do_op(input string tag, input logic s, input logic [2:0] m,
                         input logic [31:0] d, input logic [31:0] a, input logic [31:0] exp_res);
        issue(s, m, d, a);
        wait_done(tag, ref_latency(s, m, a), exp_res, m > 3'd4);
        tick();
        check({tag, " done pulse"}, {31'd0, done_s}, 32'd0);
        check({tag, " illegal drop"}, {31'd0, illegal_s}, 32'd0);
        check({tag, " result held"}, result_s, exp_res);
    endtask

    initial begin
        logic [2:0]  rm;
        logic [31:0] rd;
        logic [31:0] ra;
        logic        rs;
        int          seen;

        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            check("reset busy", {31'd0, busy_s}, 32'd0);
            check("reset done", {31'd0, done_s}, 32'd0);
            check("reset result", result_s, 32'd0);
            check("reset zero", {31'd0, zero_s}, 32'd0);
            check("reset illegal", {31'd0, illegal_s}, 32'd0);
        end
        clear = 1'b0;
        tick();

        do_op("ror8 s1", 1'b0, 3'd3, 32'hABCD1234, 32'd8, 32'h34ABCD12);
        do_op("ror8 s4", 1'b1, 3'd3, 32'hABCD1234, 32'd8, 32'h34ABCD12);
        do_op("rol1 s4", 1'b1, 3'd4, 32'h80000001, 32'd1, 32'h00000003);
        do_op("shra4", 1'b0, 3'd1, 32'h80000000, 32'd4, 32'hF8000000);
        do_op("shr4", 1'b1, 3'd0, 32'h80000000, 32'd4, 32'h08000000);
        do_op("shl40", 1'b0, 3'd2, 32'h0000FFFF, 32'd40, 32'h00FFFF00);
        do_op("shl40 s4", 1'b1, 3'd2, 32'h0000FFFF, 32'd40, 32'h00FFFF00);
        do_op("shr1 zero", 1'b0, 3'd0, 32'h00000001, 32'd1, 32'h00000000);
        do_op("amt0", 1'b0, 3'd3, 32'h12345678, 32'd0, 32'h12345678);
        do_op("mode7", 1'b0, 3'd7, 32'h12345678, 32'd5, 32'h12345678);
        do_op("mode5 s4", 1'b1, 3'd5, 32'h12345678, 32'd0, 32'h12345678);

        // Start pulsed mid-operation must not disturb the running ROR.
        issue(1'b0, 3'd3, 32'hABCD1234, 32'd8);
        tick();
        tick();
        mode = 3'd2;
        data_in = 32'h0F0F0F0F;
        amount = 32'd1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done("ignore start", 5, 32'h34ABCD12, 1'b0);

        // Back-to-back: start asserted in the done cycle.
        mode = 3'd0;
        data_in = 32'hF0000000;
        amount = 32'd4;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done("back2back", 4, 32'h0F000000, 1'b0);
        tick();

        // Clear mid-SHIFT aborts the operation without a done pulse.
        issue(1'b0, 3'd3, 32'hABCD1234, 32'd8);
        tick();
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort busy", {31'd0, busy_a}, 32'd0);
        check("abort result", result_a, 32'd0);
        check("abort zero", {31'd0, zero_a}, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_a === 1'b1) seen++;
            tick();
        end
        check("abort no done", seen, 0);

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            rm = 3'($urandom_range(0, 7));
            rd = $urandom;
            ra = (i % 4 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            do_op("random", rs, rm, rd, ra, ref_shift(rm, rd, ra));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    always @(negedge clock) begin
        if ((busy_a && done_a) || (busy_b && done_b)) begin
            total++;
            bad++;
            $error("FAIL busy_done_overlap: observed=1 expected=0");
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Multi-cycle, parametrised shift/rotate unit for the Mini SRC datapath. It generalises the single-cycle ROR/ROL/SHR/SHRA/SHL ALU paths into one iterative engine with configurable width and bits-per-cycle, and adds a start/done handshake. It sits beside the ALU. Its inputs come from Y and the bus, and its result is written toward Z.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of 2, at least 8.
STEP, 1, maximum bits shifted per SHIFT cycle; must be a power of 2, at most WIDTH.
AMT_W, log2(WIDTH), width of the effective shift amount; derived, not overridden.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
clear  input  1  synchronous, active-high reset.
start  input  1  request a new operation; sampled on the rising edge.
mode  input  3  operation select: 0 SHR, 1 SHRA, 2 SHL, 3 ROR, 4 ROL, 5-7 illegal.
data_in  input  WIDTH  operand to shift; latched on an accepted start.
amount  input  WIDTH  shift count as read from the bus; only the low AMT_W bits are used.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse; result is valid in that cycle.
result  output  WIDTH  final value; held until the next completion.
zero  output  1  result == 0; updated together with result.
illegal  output  1  high with done when the completed operation had an illegal mode.

Behaviour:
- FSM states: IDLE, SHIFT, DONE. In reset (clear=1 at an edge):
  - state=IDLE
  - busy=0, done=0, illegal=0, zero=0
  - result=0, and all internal registers cleared.
- clear has priority over every other input, including mid-operation; an operation in flight is aborted and no done is produced.
- Accepting start (start=1 at edge k while state is IDLE or DONE):
  - Latch data_in into the working register and latch mode.
  - remaining = amount[AMT_W-1:0], i.e. the count is taken modulo WIDTH for all modes (40 on a 32-bit unit means 8).
  - If the mode is illegal, or remaining == 0: go to DONE with the working register unchanged.
  - Otherwise go to SHIFT.
- start while in SHIFT is ignored; the latched operands are unaffected.
- SHIFT, each cycle:
  - s = min(STEP, remaining); shift the working register by s bits; remaining -= s.
  - When remaining reaches 0 at this edge, go to DONE.
- Shift semantics for s bits:
  - SHR: zero fill from the MSB side.
  - SHRA: MSB replicated.
  - SHL: zero fill from the LSB side.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - ROL: bits leaving the MSB re-enter at the LSB.
- Result update: on entry to DONE, result, zero and illegal are registered from the working register and mode. During SHIFT, result keeps its previous value.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next state is SHIFT or DONE if start is accepted at that edge (back-to-back operation), else IDLE.
  - illegal drops to 0 when leaving DONE.
- Latency: done is high in the cycle following edge k + ceil(remaining/STEP), where k is the accepting edge. For remaining=0 or an illegal mode, that is the cycle right after edge k.
- busy and done are never high together.
- An illegal mode returns result = data_in unshifted, with illegal=1.

Test Plan:
- STEP=1, WIDTH=32: ROR 0xABCD1234 by 8 -> busy for 8 cycles; done in the cycle after edge k+8; result=0x34ABCD12, zero=0.
- STEP=4: same ROR -> done in the cycle after edge k+2, result=0x34ABCD12. Then ROL 0x80000001 by 1 -> result=0x00000003 after 1 SHIFT cycle.
- SHRA 0x80000000 by 4 -> 0xF8000000. SHR 0x80000000 by 4 -> 0x08000000. SHL 0x0000FFFF by 40 (mod 32 = 8) -> 0x00FFFF00. SHR 0x00000001 by 1 -> 0x00000000, zero=1.
- Amount 0 and illegal mode 7 with data_in 0x12345678 -> done the cycle after the start edge; result=0x12345678; illegal=1 for mode 7 only.
- Start a ROR by 8, then pulse start with different operands at cycle 3 -> ignored; original result produced. Start asserted during done -> new operation accepted back-to-back.
- Assert clear at SHIFT cycle 4 -> next cycle state IDLE, busy=0, result=0, and no done pulse follows.
